// File: rtl/data_mem_if.sv
// MEM-stage data memory bus: store/load controls, address and write data in;
// aligned read word and misalignment flag out.
interface data_mem_if;
    logic        MemWrite;
    logic [1:0]  store_Sel;
    logic [2:0]  load_Sel;
    logic        MemRead;
    logic [31:0] addr;
    logic [31:0] WD;
    logic [31:0] RD_tmp;
    logic        addr_err;

    modport master (
        output MemWrite, store_Sel, load_Sel, MemRead, addr, WD,
        input  RD_tmp, addr_err
    );

    modport slave (
        input  MemWrite, store_Sel, load_Sel, MemRead, addr, WD,
        output RD_tmp, addr_err
    );
endinterface

// File: rtl/data_mem.sv
// Word-organised data memory with byte-lane stores (sw/sh/sb) and misalignment detection.
// Reads are combinational (0 cycles), stores commit at the clock edge; no backpressure.
module data_mem #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic      clk,
    input  logic      reset,
    data_mem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  store_err;
    logic                  load_err;
    logic                  wr_en;
    logic [3:0]            byte_en;
    logic [31:0]           wr_dat;
    logic [31:0]           word_d;
    logic                  unused_addr_hi;

    // Upper address bits are ignored: the memory aliases across the full byte space.
    assign idx            = bus.addr[ADDR_WIDTH+1:2];
    assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];

    always_comb begin
        store_err = 1'b0;
        if (bus.MemWrite) begin
            case (bus.store_Sel)
                2'b00:   store_err = (bus.addr[1:0] != 2'b00);
                2'b10:   store_err = bus.addr[0];
                default: store_err = 1'b0;
            endcase
        end
    end

    always_comb begin
        load_err = 1'b0;
        if (bus.MemRead) begin
            case (bus.load_Sel)
                3'b000:        load_err = (bus.addr[1:0] != 2'b00);
                3'b001, 3'b011: load_err = 1'b0;
                3'b010, 3'b100: load_err = bus.addr[0];
                default:       load_err = 1'b1;
            endcase
        end
    end

    assign bus.addr_err = store_err | load_err;

    always_comb begin
        byte_en = 4'b0000;
        wr_dat  = bus.WD;
        case (bus.store_Sel)
            2'b00: byte_en = 4'b1111;
            2'b01: begin
                byte_en = 4'b0001 << bus.addr[1:0];
                wr_dat  = {4{bus.WD[7:0]}};
            end
            2'b10: begin
                byte_en = bus.addr[1] ? 4'b1100 : 4'b0011;
                wr_dat  = {2{bus.WD[15:0]}};
            end
            default: byte_en = 4'b0000;
        endcase
    end

    // Any flagged misalignment this cycle, load or store, suppresses the whole store.
    assign wr_en = bus.MemWrite && !bus.addr_err && (bus.store_Sel != 2'b11);

    always_comb begin
        word_d = mem_q[idx];
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                word_d[8*b +: 8] = wr_dat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= word_d;
        end
    end

    assign bus.RD_tmp = mem_q[idx];
endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: scoreboard of expected RD_tmp/addr_err per driven cycle.
module tb_data_mem;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    data_mem_if bus();

    data_mem #(.ADDR_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [1:0] SW = 2'b00, SB = 2'b01, SH = 2'b10, SRSV = 2'b11;
    localparam logic [2:0] LW = 3'b000, LB = 3'b001, LH = 3'b010, LBU = 3'b011, LHU = 3'b100;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        logic        mw;
        logic [1:0]  ss;
        logic        mr;
        logic [2:0]  ls;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } step_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Drive one cycle of stimulus just after the falling edge and record what the DUT must show.
    task automatic apply(input step_t s);
        @(negedge clk);
        bus.MemWrite  = s.mw;
        bus.store_Sel = s.ss;
        bus.MemRead   = s.mr;
        bus.load_Sel  = s.ls;
        bus.addr      = s.a;
        bus.WD        = s.wd;
        exp_q.push_back('{s.rd, s.err});
        #1;
    endtask

    task automatic test_reset();
        step_t st[2];
        exp_t  e;
        @(negedge clk);
        reset = 1'b1;
        bus.MemWrite = 1'b0; bus.MemRead = 1'b0; bus.store_Sel = SW; bus.load_Sel = LW;
        bus.addr = 32'h0; bus.WD = 32'h0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.addr_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_addr_err: addr_err=%b, expected 0", bus.addr_err);
        end
        reset = 1'b0;
        st[0] = '{1'b0, SW, 1'b1, LW, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0};
        st[1] = '{1'b0, SW, 1'b1, LW, 32'h0000_0FFC, 32'h0, 32'h0000_0000, 1'b0};
        foreach (st[i]) begin
            apply(st[i]);
            e = exp_q.pop_front();
            checks++;
            if (bus.RD_tmp !== e.rd || bus.addr_err !== e.err) begin
                fails++;
                $display("FAIL reset_read%0d: RD_tmp=%h addr_err=%b, expected %h %b",
                         i, bus.RD_tmp, bus.addr_err, e.rd, e.err);
            end
        end
    endtask

    task automatic test_store_word();
        step_t st[3];
        exp_t  e;
        st[0] = '{1'b1, SW, 1'b0, LW, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0};
        st[1] = '{1'b0, SW, 1'b1, LW, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};
        st[2] = '{1'b0, SW, 1'b1, LW, 32'h0000_0014, 32'h0,         32'h0000_0000, 1'b0};
        foreach (st[i]) begin
            apply(st[i]);
            e = exp_q.pop_front();
            checks++;
            if (bus.RD_tmp !== e.rd || bus.addr_err !== e.err) begin
                fails++;
                $display("FAIL store_word%0d: RD_tmp=%h addr_err=%b, expected %h %b",
                         i, bus.RD_tmp, bus.addr_err, e.rd, e.err);
            end
        end
    endtask

    task automatic test_byte_half();
        step_t st[4];
        exp_t  e;
        st[0] = '{1'b1, SB, 1'b0, LW, 32'h0000_0011, 32'h0000_00AB, 32'h1234_5678, 1'b0};
        st[1] = '{1'b0, SW, 1'b1, LW, 32'h0000_0010, 32'h0,         32'h1234_AB78, 1'b0};
        st[2] = '{1'b1, SH, 1'b0, LW, 32'h0000_0012, 32'h0000_BEEF, 32'h1234_AB78, 1'b0};
        st[3] = '{1'b0, SW, 1'b1, LW, 32'h0000_0010, 32'h0,         32'hBEEF_AB78, 1'b0};
        foreach (st[i]) begin
            apply(st[i]);
            e = exp_q.pop_front();
            checks++;
            if (bus.RD_tmp !== e.rd || bus.addr_err !== e.err) begin
                fails++;
                $display("FAIL byte_half%0d: RD_tmp=%h addr_err=%b, expected %h %b",
                         i, bus.RD_tmp, bus.addr_err, e.rd, e.err);
            end
        end
    endtask

    task automatic test_misaligned();
        step_t st[13];
        exp_t  e;
        st[0]  = '{1'b1, SW,   1'b0, LW,     32'h0000_0013, 32'hFFFF_FFFF, 32'hBEEF_AB78, 1'b1};
        st[1]  = '{1'b1, SH,   1'b0, LW,     32'h0000_0011, 32'hFFFF_FFFF, 32'hBEEF_AB78, 1'b1};
        st[2]  = '{1'b0, SW,   1'b1, LW,     32'h0000_0010, 32'h0,         32'hBEEF_AB78, 1'b0};
        st[3]  = '{1'b0, SW,   1'b1, LW,     32'h0000_0002, 32'h0,         32'h0000_0000, 1'b1};
        st[4]  = '{1'b0, SW,   1'b1, LH,     32'h0000_0003, 32'h0,         32'h0000_0000, 1'b1};
        st[5]  = '{1'b0, SW,   1'b1, LHU,    32'h0000_0001, 32'h0,         32'h0000_0000, 1'b1};
        st[6]  = '{1'b0, SW,   1'b1, LB,     32'h0000_0003, 32'h0,         32'h0000_0000, 1'b0};
        st[7]  = '{1'b0, SW,   1'b1, LBU,    32'h0000_0001, 32'h0,         32'h0000_0000, 1'b0};
        st[8]  = '{1'b0, SW,   1'b1, LH,     32'h0000_0002, 32'h0,         32'h0000_0000, 1'b0};
        st[9]  = '{1'b0, SW,   1'b1, 3'b101, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b1};
        st[10] = '{1'b0, SW,   1'b0, LW,     32'h0000_0002, 32'h0,         32'h0000_0000, 1'b0};
        st[11] = '{1'b1, SRSV, 1'b0, LW,     32'h0000_0010, 32'h0,         32'hBEEF_AB78, 1'b0};
        st[12] = '{1'b0, SW,   1'b1, LW,     32'h0000_0010, 32'h0,         32'hBEEF_AB78, 1'b0};
        foreach (st[i]) begin
            apply(st[i]);
            e = exp_q.pop_front();
            checks++;
            if (bus.RD_tmp !== e.rd || bus.addr_err !== e.err) begin
                fails++;
                $display("FAIL misaligned%0d: RD_tmp=%h addr_err=%b, expected %h %b",
                         i, bus.RD_tmp, bus.addr_err, e.rd, e.err);
            end
        end
    endtask

    task automatic test_alias();
        step_t st[4];
        exp_t  e;
        st[0] = '{1'b1, SW, 1'b0, LW, 32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        st[1] = '{1'b0, SW, 1'b1, LW, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};
        st[2] = '{1'b0, SW, 1'b1, LW, 32'h0000_1000, 32'h0,         32'hCAFE_F00D, 1'b0};
        st[3] = '{1'b0, SW, 1'b1, LW, 32'hFFFF_F000, 32'h0,         32'hCAFE_F00D, 1'b0};
        foreach (st[i]) begin
            apply(st[i]);
            e = exp_q.pop_front();
            checks++;
            if (bus.RD_tmp !== e.rd || bus.addr_err !== e.err) begin
                fails++;
                $display("FAIL alias%0d: RD_tmp=%h addr_err=%b, expected %h %b",
                         i, bus.RD_tmp, bus.addr_err, e.rd, e.err);
            end
        end
    endtask

    // Random aligned stores every cycle into words 0x40..0x5C, checked against a byte-lane model.
    task automatic test_back_to_back();
        logic [31:0] model [8];
        step_t       s;
        exp_t        e;
        int          w;
        int          lane;
        foreach (model[i]) model[i] = 32'h0;
        for (int n = 0; n < 40; n++) begin
            w    = int'($urandom_range(0, 7));
            s.mw = 1'b1;
            s.mr = 1'b0;
            s.ls = LW;
            s.wd = $urandom;
            s.ss = 2'($urandom_range(0, 2));
            case (s.ss)
                SB:      lane = int'($urandom_range(0, 3));
                SH:      lane = 2 * int'($urandom_range(0, 1));
                default: lane = 0;
            endcase
            s.a   = 32'h40 + 32'(4 * w) + 32'(lane);
            s.rd  = model[w];
            s.err = 1'b0;
            apply(s);
            e = exp_q.pop_front();
            checks++;
            if (bus.RD_tmp !== e.rd || bus.addr_err !== e.err) begin
                fails++;
                $display("FAIL b2b_store%0d: RD_tmp=%h addr_err=%b, expected %h %b",
                         n, bus.RD_tmp, bus.addr_err, e.rd, e.err);
            end
            case (s.ss)
                SB:      model[w][8*lane +: 8]  = s.wd[7:0];
                SH:      model[w][8*lane +: 16] = s.wd[15:0];
                default: model[w]               = s.wd;
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            s = '{1'b0, SW, 1'b1, LW, 32'h40 + 32'(4 * i), 32'h0, model[i], 1'b0};
            apply(s);
            e = exp_q.pop_front();
            checks++;
            if (bus.RD_tmp !== e.rd || bus.addr_err !== e.err) begin
                fails++;
                $display("FAIL b2b_read%0d: RD_tmp=%h addr_err=%b, expected %h %b",
                         i, bus.RD_tmp, bus.addr_err, e.rd, e.err);
            end
        end
    endtask

    task automatic test_reset_priority();
        logic [31:0] addrs [6];
        step_t       s;
        exp_t        e;
        addrs = '{32'h20, 32'h10, 32'h0, 32'h40, 32'h4C, 32'h5C};
        @(negedge clk);
        reset = 1'b1;
        bus.MemWrite = 1'b1; bus.store_Sel = SW; bus.MemRead = 1'b0; bus.load_Sel = LW;
        bus.addr = 32'h20; bus.WD = 32'h1111_1111;
        @(negedge clk);
        reset = 1'b0;
        bus.MemWrite = 1'b0;
        foreach (addrs[i]) begin
            s = '{1'b0, SW, 1'b1, LW, addrs[i], 32'h0, 32'h0, 1'b0};
            apply(s);
            e = exp_q.pop_front();
            checks++;
            if (bus.RD_tmp !== e.rd || bus.addr_err !== e.err) begin
                fails++;
                $display("FAIL reset_prio@%h: RD_tmp=%h addr_err=%b, expected %h %b",
                         addrs[i], bus.RD_tmp, bus.addr_err, e.rd, e.err);
            end
        end
    endtask

    initial begin
        bus.MemWrite  = 1'b0;
        bus.store_Sel = SW;
        bus.MemRead   = 1'b0;
        bus.load_Sel  = LW;
        bus.addr      = 32'h0;
        bus.WD        = 32'h0;
        test_reset();
        test_store_word();
        test_byte_half();
        test_misaligned();
        test_alias();
        test_back_to_back();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
